// File: rtl/cpu_clock_ctrl.sv
// Purpose: turns the divided slow_clk square wave into single-cycle cpu_en
//          strobes, with free-run, debounced single-step and halt modes.
// Latency: cpu_en rises on the 3rd clock_in edge after slow_clk is first seen high.
// Backpressure: none; halt_req and run_mode gate the strobes, nothing is queued.
//
// Ports:
//   clock_in     - the only clock
//   reset        - synchronous, active-high
//   slow_clk     - divided clock, sampled as asynchronous data
//   run_mode     - 1 = free run, 0 = single step (asynchronous switch)
//   step_btn     - raw active-high push button (asynchronous, bouncy)
//   halt_req     - processor halt request, clock_in domain level
//   cpu_en       - one-cycle processor advance enable (registered)
//   halted       - high while the FSM is in HALTED
//   state        - 00 IDLE, 01 RUN, 10 STEP_WAIT, 11 HALTED
//   instr_count  - cpu_en pulses since reset, wrapping
module cpu_clock_ctrl #(
  parameter logic [27:0] DEBOUNCE_CYCLES = 28'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             run_mode,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  state_t      cur_state, nxt_state;
  logic        arm, nxt_arm, nxt_en;

  logic [1:0]  slow_sync, run_sync, btn_sync;
  logic        prev_slow;
  logic        btn_db, btn_db_q;
  logic [27:0] db_cnt;

  logic        sync_slow, sync_run, sync_btn;
  logic        tick, step_pulse;

  assign sync_slow  = slow_sync[1];
  assign sync_run   = run_sync[1];
  assign sync_btn   = btn_sync[1];
  assign tick       = sync_slow & ~prev_slow;
  // Only the press edge of the debounced button steps; release is ignored.
  assign step_pulse = btn_db & ~btn_db_q;
  assign state      = cur_state;

  // Synchronizers, edge detector and button debounce.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      slow_sync <= 2'b00;
      run_sync  <= 2'b00;
      btn_sync  <= 2'b00;
      prev_slow <= 1'b0;
      btn_db    <= 1'b0;
      btn_db_q  <= 1'b0;
      db_cnt    <= '0;
    end else begin
      slow_sync <= {slow_sync[0], slow_clk};
      run_sync  <= {run_sync[0], run_mode};
      btn_sync  <= {btn_sync[0], step_btn};
      prev_slow <= sync_slow;
      btn_db_q  <= btn_db;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (sync_btn == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DEBOUNCE_CYCLES - 28'd1) begin
        btn_db <= sync_btn;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 28'd1;
      end
    end
  end

  // FSM state register, registered outputs and pulse counter.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      cur_state   <= S_IDLE;
      arm         <= 1'b0;
      cpu_en      <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      cur_state <= nxt_state;
      arm       <= nxt_arm;
      cpu_en    <= nxt_en;
      halted    <= (nxt_state == S_HALTED);
      if (cpu_en) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  // Next state. Priority: halt_req, then a run_mode change, then tick/step.
  // run_mode is only seen through its synchronizer, so leaving reset with the
  // switch already at RUN passes briefly through STEP_WAIT before RUN.
  always_comb begin
    nxt_state = cur_state;
    nxt_arm   = arm;
    nxt_en    = 1'b0;
    case (cur_state)
      S_IDLE: begin
        nxt_arm   = 1'b0;
        nxt_state = sync_run ? S_RUN : S_STEP;
      end
      S_RUN: begin
        nxt_arm = 1'b0;
        if (halt_req) begin
          nxt_state = S_HALTED;
        end else if (!sync_run) begin
          nxt_state = S_STEP;
        end else begin
          nxt_en = tick;
        end
      end
      S_STEP: begin
        if (halt_req) begin
          nxt_state = S_HALTED;
          nxt_arm   = 1'b0;
        end else if (sync_run) begin
          nxt_state = S_RUN;
          nxt_arm   = 1'b0;
        end else if (arm && tick) begin
          nxt_en  = 1'b1;
          nxt_arm = 1'b0;
        end else if (step_pulse) begin
          // A press while already armed leaves arm set: steps do not queue.
          nxt_arm = 1'b1;
        end
      end
      S_HALTED: begin
        nxt_arm = 1'b0;
        if (step_pulse) begin
          nxt_state = sync_run ? S_RUN : S_STEP;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_arm   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Purpose: directed bench for cpu_clock_ctrl (DEBOUNCE_CYCLES=4, CNT_W=4).
// Latency: outputs sampled 1 time unit after each rising clock_in edge.
// Backpressure: not applicable.
module tb_cpu_clock_ctrl;

  logic       clock_in = 1'b0;
  logic       reset, slow_clk, run_mode, step_btn, halt_req;
  logic       cpu_en, halted;
  logic [1:0] state;
  logic [3:0] instr_count;

  int checks   = 0;
  int failures = 0;

  // Per-cycle observers, cleared by clear_obs.
  int n_step, n_en, n_run, last_en_pos;
  logic halt_lvl = 1'b0;
  logic [3:0] exp_cnt;

  cpu_clock_ctrl #(.DEBOUNCE_CYCLES(28'd4), .CNT_W(4)) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .slow_clk    (slow_clk),
    .run_mode    (run_mode),
    .step_btn    (step_btn),
    .halt_req    (halt_req),
    .cpu_en      (cpu_en),
    .halted      (halted),
    .state       (state),
    .instr_count (instr_count)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic       rst, slow, run, btn, halt;
    logic       e_en, e_halted;
    logic [1:0] e_state;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    n_step = 0; n_en = 0; n_run = 0; last_en_pos = -1;
  endtask

  task automatic cyc(input int idx);
    @(posedge clock_in);
    #1;
    if (dut.step_pulse) n_step++;
    if (cpu_en) begin n_en++; last_en_pos = idx; end
    if (state == 2'b01) n_run++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(-1);
  endtask

  task automatic press(input int hold);
    step_btn = 1'b1;
    idle_cycles(hold);
    step_btn = 1'b0;
    idle_cycles(8);
  endtask

  // One slow_clk period: 10 cycles low then 10 high. A rising edge at index 10
  // should give cpu_en at index 12. Optional one-cycle halt or reset strobes.
  task automatic run_period(input int halt_at, input int rst_at);
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      slow_clk = (i >= 10);
      halt_req = halt_lvl | (i == halt_at);
      reset    = (i == rst_at);
      cyc(i);
      if (i == halt_at) begin
        check("halt_same_tick_en", cpu_en, 0);
        check("halt_state", state, 2'b11);
        check("halt_flag", halted, 1);
      end
      if (i == rst_at) begin
        check("rst_mid_state", state, 2'b00);
        check("rst_mid_cnt", instr_count, 0);
        check("rst_mid_en", cpu_en, 0);
      end
      if (rst_at >= 0 && i == rst_at + 1) check("rst_after_state", state, 2'b10);
    end
    halt_req = halt_lvl;
    reset    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; slow_clk = 1'b0; run_mode = 1'b1; step_btn = 1'b0; halt_req = 1'b0;
    clear_obs();

    //                rst   slow  run   btn   halt  en    hlt   state  cnt
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'd0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd1};

    // Reset, start-up and first slow_clk rise (cpu_en on 3rd edge).
    for (int v = 0; v < 9; v++) begin
      reset = tbl[v].rst; slow_clk = tbl[v].slow; run_mode = tbl[v].run;
      step_btn = tbl[v].btn; halt_req = tbl[v].halt;
      cyc(v);
      check($sformatf("vec%0d_en", v), cpu_en, tbl[v].e_en);
      check($sformatf("vec%0d_halted", v), halted, tbl[v].e_halted);
      check($sformatf("vec%0d_state", v), state, tbl[v].e_state);
      check($sformatf("vec%0d_cnt", v), instr_count, tbl[v].e_cnt);
    end
    slow_clk = 1'b0;

    // Free run: one pulse per period, 2 cycles after the rise is applied.
    for (int p = 0; p < 4; p++) begin
      run_period(-1, -1);
      check("run_pulses", n_en, 1);
      check("run_pulse_pos", last_en_pos, 12);
    end
    check("run_cnt5", instr_count, 5);

    // Counter wrap 15 -> 0 -> 1.
    for (int p = 0; p < 10; p++) run_period(-1, -1);
    check("wrap_cnt15", instr_count, 15);
    run_period(-1, -1);
    check("wrap_cnt0", instr_count, 0);
    run_period(-1, -1);
    check("wrap_cnt1", instr_count, 1);
    exp_cnt = 4'd1;

    // Single step with a bouncing button.
    run_mode = 1'b0;
    idle_cycles(4);
    check("step_state", state, 2'b10);
    clear_obs();
    step_btn = 1'b1; idle_cycles(1);
    step_btn = 1'b0; idle_cycles(1);
    step_btn = 1'b1; idle_cycles(10);
    step_btn = 1'b0; idle_cycles(10);
    check("bounce_step_pulses", n_step, 1);
    check("bounce_no_en_yet", n_en, 0);
    run_period(-1, -1);
    check("step_one_en", n_en, 1);
    check("step_en_pos", last_en_pos, 12);
    exp_cnt = exp_cnt + 4'd1;
    run_period(-1, -1);
    check("step_no_more_en", n_en, 0);
    check("step_cnt", instr_count, exp_cnt);

    // Halt on the same cycle as a tick, then ticks ignored.
    run_mode = 1'b1;
    idle_cycles(4);
    check("back_to_run", state, 2'b01);
    run_period(12, -1);
    check("halt_period_en", n_en, 0);
    clear_obs();
    for (int p = 0; p < 3; p++) begin
      run_period(-1, -1);
      check("halted_ticks_en", n_en, 0);
      check("halted_stays", state, 2'b11);
    end

    // Resume from HALTED with a clean press.
    press(8);
    check("resume_state", state, 2'b01);
    check("resume_halted", halted, 0);
    run_period(-1, -1);
    check("resume_en", n_en, 1);
    exp_cnt = exp_cnt + 4'd1;
    check("resume_cnt", instr_count, exp_cnt);

    // Resume with halt_req held: one RUN cycle, then HALTED, no cpu_en.
    run_period(12, -1);
    halt_lvl = 1'b1;
    halt_req = 1'b1;
    clear_obs();
    press(8);
    check("rehalt_run_cycles", n_run, 1);
    check("rehalt_en", n_en, 0);
    check("rehalt_state", state, 2'b11);
    halt_lvl = 1'b0;
    halt_req = 1'b0;

    // Reset while a step is armed discards it.
    run_mode = 1'b0;
    idle_cycles(4);
    press(8);
    check("to_step_wait", state, 2'b10);
    press(8);
    run_period(-1, 11);
    check("armed_reset_en", n_en, 0);
    check("armed_reset_cnt", instr_count, 0);
    check("armed_reset_state", state, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
